// File: rtl/floo_tile_link_isolator.sv
// Purpose : per-port quiesce/isolation of NumPorts x NumChannels valid/ready/last links (egress and ingress).
// Latency : zero-cycle combinational passthrough; isolation state and iso_ack_o are registered.
// Backpr. : busy streams always pass ready through; idle streams are gated in DRAIN; ISOLATED stalls
//           (ready=0) or sinks-and-counts (ready=1) depending on DropWhenIsolated.
//
// Ports:
//   clk_i, rst_ni                      clock, async active-low reset
//   iso_req_i[p] / iso_ack_o[p]        level isolation request / port fully isolated
//   drop_cnt_o[p], drop_clr_i[p]       saturating discarded-flit counter and its synchronous clear
//   egr_*_i / egr_*_o                  tile -> block / block -> link, [port][channel]
//   ing_*_i / ing_*_o                  link -> block / block -> tile, [port][channel]
module floo_tile_link_isolator #(
    parameter int unsigned NumPorts         = 4,
    parameter int unsigned NumChannels      = 3,
    parameter int unsigned DataWidth        = 512,
    parameter bit          DropWhenIsolated = 1'b0,
    parameter int unsigned CntWidth         = 16
) (
    input  logic                                                 clk_i,
    input  logic                                                 rst_ni,
    input  logic [NumPorts-1:0]                                  iso_req_i,
    output logic [NumPorts-1:0]                                  iso_ack_o,
    output logic [NumPorts-1:0][CntWidth-1:0]                    drop_cnt_o,
    input  logic [NumPorts-1:0]                                  drop_clr_i,
    input  logic [NumPorts-1:0][NumChannels-1:0]                 egr_valid_i,
    output logic [NumPorts-1:0][NumChannels-1:0]                 egr_ready_o,
    input  logic [NumPorts-1:0][NumChannels-1:0]                 egr_last_i,
    input  logic [NumPorts-1:0][NumChannels-1:0][DataWidth-1:0]  egr_data_i,
    output logic [NumPorts-1:0][NumChannels-1:0]                 egr_valid_o,
    input  logic [NumPorts-1:0][NumChannels-1:0]                 egr_ready_i,
    output logic [NumPorts-1:0][NumChannels-1:0]                 egr_last_o,
    output logic [NumPorts-1:0][NumChannels-1:0][DataWidth-1:0]  egr_data_o,
    input  logic [NumPorts-1:0][NumChannels-1:0]                 ing_valid_i,
    output logic [NumPorts-1:0][NumChannels-1:0]                 ing_ready_o,
    input  logic [NumPorts-1:0][NumChannels-1:0]                 ing_last_i,
    input  logic [NumPorts-1:0][NumChannels-1:0][DataWidth-1:0]  ing_data_i,
    output logic [NumPorts-1:0][NumChannels-1:0]                 ing_valid_o,
    input  logic [NumPorts-1:0][NumChannels-1:0]                 ing_ready_i,
    output logic [NumPorts-1:0][NumChannels-1:0]                 ing_last_o,
    output logic [NumPorts-1:0][NumChannels-1:0][DataWidth-1:0]  ing_data_o
);

    // Streams per port: [0..NumChannels-1] egress, [NumChannels..2*NumChannels-1] ingress.
    localparam int unsigned NS = 2 * NumChannels;
    localparam int unsigned IW = $clog2(NS + 1);
    localparam int unsigned SW = CntWidth + IW;

    typedef enum logic [1:0] {
        ST_ACTIVE   = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_ISOLATED = 2'd2
    } state_t;

    state_t r_state     [NumPorts];
    state_t w_state_nxt [NumPorts];

    logic [NumPorts-1:0][NS-1:0] w_vin, w_rdn, w_lst;
    logic [NumPorts-1:0][NS-1:0] w_pass, w_vout, w_rup, w_hs, w_busy;
    logic [NumPorts-1:0][NS-1:0] r_open, r_pend;
    logic [NumPorts-1:0][IW-1:0] w_inc;
    logic [NumPorts-1:0][SW-1:0] w_sum;
    logic [NumPorts-1:0][CntWidth-1:0] w_cnt_nxt;
    logic [NumPorts-1:0][CntWidth-1:0] r_cnt;

    // Payload and last are never modified; only valid/ready are gated.
    assign egr_data_o = egr_data_i;
    assign egr_last_o = egr_last_i;
    assign ing_data_o = ing_data_i;
    assign ing_last_o = ing_last_i;
    assign drop_cnt_o = r_cnt;

    for (genvar p = 0; p < NumPorts; p++) begin : g_port
        assign iso_ack_o[p] = (r_state[p] == ST_ISOLATED);
        for (genvar c = 0; c < NumChannels; c++) begin : g_chan
            assign w_vin[p][c]             = egr_valid_i[p][c];
            assign w_rdn[p][c]             = egr_ready_i[p][c];
            assign w_lst[p][c]             = egr_last_i[p][c];
            assign w_vin[p][NumChannels+c] = ing_valid_i[p][c];
            assign w_rdn[p][NumChannels+c] = ing_ready_i[p][c];
            assign w_lst[p][NumChannels+c] = ing_last_i[p][c];
            assign egr_valid_o[p][c]       = w_vout[p][c];
            assign egr_ready_o[p][c]       = w_rup[p][c];
            assign ing_valid_o[p][c]       = w_vout[p][NumChannels+c];
            assign ing_ready_o[p][c]       = w_rup[p][NumChannels+c];
        end
    end

    // Per-port FSM next state plus stream gating and drop accounting.
    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            w_state_nxt[p] = r_state[p];
            w_pass[p]      = '0;
            w_vout[p]      = '0;
            w_rup[p]       = '0;
            w_hs[p]        = '0;
            w_busy[p]      = '0;
            w_inc[p]       = '0;
            for (int s = 0; s < NS; s++) begin
                case (r_state[p])
                    ST_ACTIVE: w_pass[p][s] = 1'b1;
                    // Only streams with a packet or a stalled flit in flight keep flowing.
                    ST_DRAIN:  w_pass[p][s] = r_open[p][s] | r_pend[p][s];
                    default:   w_pass[p][s] = 1'b0;
                endcase
                w_vout[p][s] = w_vin[p][s] & w_pass[p][s];
                w_rup[p][s]  = (r_state[p] == ST_ISOLATED) ? DropWhenIsolated
                                                           : (w_rdn[p][s] & w_pass[p][s]);
                w_hs[p][s]   = w_vout[p][s] & w_rdn[p][s];
                // valid_o is already gated, so this term cannot loop back into w_pass.
                w_busy[p][s] = r_open[p][s] | r_pend[p][s] | (w_vout[p][s] & ~w_rdn[p][s]);
                if ((r_state[p] == ST_ISOLATED) && DropWhenIsolated && w_vin[p][s]) begin
                    w_inc[p] = w_inc[p] + IW'(1);
                end
            end

            case (r_state[p])
                ST_ACTIVE: begin
                    if (iso_req_i[p]) w_state_nxt[p] = ST_DRAIN;
                end
                ST_DRAIN: begin
                    // A withdrawn request wins over completion, so no ack is ever flashed.
                    if (!iso_req_i[p])     w_state_nxt[p] = ST_ACTIVE;
                    else if (~|w_busy[p])  w_state_nxt[p] = ST_ISOLATED;
                end
                ST_ISOLATED: begin
                    if (!iso_req_i[p]) w_state_nxt[p] = ST_ACTIVE;
                end
                default: w_state_nxt[p] = ST_ACTIVE;
            endcase

            w_sum[p] = SW'(r_cnt[p]) + SW'(w_inc[p]);
            if (|w_sum[p][SW-1:CntWidth]) w_cnt_nxt[p] = '1;
            else                           w_cnt_nxt[p] = w_sum[p][CntWidth-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int p = 0; p < NumPorts; p++) r_state[p] <= ST_ACTIVE;
        end else begin
            for (int p = 0; p < NumPorts; p++) r_state[p] <= w_state_nxt[p];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_open <= '0;
            r_pend <= '0;
            r_cnt  <= '0;
        end else begin
            for (int p = 0; p < NumPorts; p++) begin
                // Discarded flits must not reopen a packet; leaving isolation starts clean.
                if (r_state[p] == ST_ISOLATED) begin
                    if (w_state_nxt[p] == ST_ACTIVE) r_open[p] <= '0;
                end else begin
                    r_open[p] <= (r_open[p] & ~w_hs[p]) | (w_hs[p] & ~w_lst[p]);
                end
                r_pend[p] <= w_vout[p] & ~w_rdn[p];
                if (drop_clr_i[p])   r_cnt[p] <= '0;
                else if (|w_inc[p])  r_cnt[p] <= w_cnt_nxt[p];
            end
        end
    end

endmodule
